// File: rtl/servo_pwm_array_if.sv
// Command port of servo_pwm_array: valid/ready writes of a per-channel target width,
// plus a one-cycle report that the accepted width was clamped into range.
interface servo_pwm_array_if #(
    parameter int CH = 4,
    parameter int W  = 20
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [CHW-1:0] cmd_ch;
    logic [W-1:0]   cmd_pw;
    logic           cmd_clamped;

    modport master (output cmd_valid, cmd_ch, cmd_pw, input  cmd_ready, cmd_clamped);
    modport slave  (input  cmd_valid, cmd_ch, cmd_pw, output cmd_ready, cmd_clamped);
endinterface

// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, per-channel target and
// applied widths, range clamping, per-frame slew limiting and a debounced nudge button.
module servo_pwm_array #(
    parameter int  CH         = 4,
    parameter int  W          = 20,
    parameter int  PERIOD_CYC = 1_000_000,
    parameter int  MIN_PW     = 25_000,
    parameter int  MAX_PW     = 125_000,
    parameter int  NEUTRAL_PW = 75_000,
    parameter int  SLEW       = 2_048,
    parameter int  STEP       = 128,
    parameter int  DEB_CYC    = 500_000,
    localparam int CHW        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             m_clock,
    input  logic             p_reset,
    servo_pwm_array_if.slave cmd,
    input  logic             push,
    input  logic             push_dn,
    input  logic [CHW-1:0]   sel_ch,
    input  logic [CH-1:0]    en,
    output logic [CH-1:0]    pwm,
    output logic             frame_tick,
    output logic [W-1:0]     disp_pw
);
    localparam int DCW = $clog2(DEB_CYC + 1);

    typedef logic [W-1:0]   pw_t;
    typedef logic [W:0]     wide_t;
    typedef logic [CHW:0]   chx_t;
    typedef logic [DCW-1:0] dcnt_t;

    localparam pw_t   LAST_CNT = pw_t'(PERIOD_CYC - 1);
    localparam pw_t   MIN_W    = pw_t'(MIN_PW);
    localparam pw_t   MAX_W    = pw_t'(MAX_PW);
    localparam pw_t   NEU_W    = pw_t'(NEUTRAL_PW);
    localparam pw_t   SLEW_W   = pw_t'(SLEW);
    localparam wide_t MIN_X    = wide_t'(MIN_PW);
    localparam wide_t MAX_X    = wide_t'(MAX_PW);
    localparam wide_t STEP_X   = wide_t'(STEP);
    localparam chx_t  CH_X     = chx_t'(CH);
    localparam dcnt_t DEB_LAST = dcnt_t'(DEB_CYC - 1);

    pw_t   cnt;
    pw_t   tgt [CH];
    pw_t   cur [CH];
    logic  ready_q;
    logic  clamped_q;
    logic  sync1, sync2, deb;
    dcnt_t deb_cnt;

    logic  accept, cmd_hit, cmd_out_of_range;
    logic  deb_flip, press, press_ok;
    pw_t   cmd_pw_clamped;

    // One extra bit holds the carry/borrow so saturation never sees a wrapped value.
    function automatic pw_t nudge(input pw_t t, input logic dn);
        wide_t v;
        if (dn) begin
            v = {1'b0, t} - STEP_X;
            if (v[W] || v < MIN_X) return MIN_W;
        end else begin
            v = {1'b0, t} + STEP_X;
            if (v > MAX_X) return MAX_W;
        end
        return v[W-1:0];
    endfunction

    function automatic pw_t slew_step(input pw_t c, input pw_t t);
        if (t >= c) return (t - c <= SLEW_W) ? t : c + SLEW_W;
        return (c - t <= SLEW_W) ? t : c - SLEW_W;
    endfunction

    assign frame_tick      = (cnt == LAST_CNT);
    assign cmd.cmd_ready   = ready_q & ~frame_tick;
    assign cmd.cmd_clamped = clamped_q;

    assign accept           = cmd.cmd_valid & cmd.cmd_ready;
    assign cmd_hit          = accept & (chx_t'(cmd.cmd_ch) < CH_X);
    assign cmd_out_of_range = (cmd.cmd_pw < MIN_W) | (cmd.cmd_pw > MAX_W);
    assign cmd_pw_clamped   = (cmd.cmd_pw < MIN_W) ? MIN_W :
                              (cmd.cmd_pw > MAX_W) ? MAX_W : cmd.cmd_pw;

    assign deb_flip = (sync2 != deb) & (deb_cnt == DEB_LAST);
    assign press    = deb_flip & deb;
    // A command to the same channel in the same cycle overrides the button.
    assign press_ok = press & (chx_t'(sel_ch) < CH_X) &
                      ~(cmd_hit & (cmd.cmd_ch == sel_ch));

    assign disp_pw = (chx_t'(sel_ch) < CH_X) ? cur[sel_ch] : '0;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            cnt       <= '0;
            ready_q   <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
            cnt       <= frame_tick ? '0 : cnt + pw_t'(1);
            ready_q   <= 1'b1;
            clamped_q <= cmd_hit & cmd_out_of_range;
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb     <= 1'b1;
            deb_cnt <= '0;
        end else begin
            sync1 <= push;
            sync2 <= sync1;
            if (sync2 == deb || deb_flip) deb_cnt <= '0;
            else                          deb_cnt <= deb_cnt + dcnt_t'(1);
            if (deb_flip) deb <= sync2;
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < CH; i++) pwm[i] <= en[i] & (cnt < cur[i]);
        end
    end

    // NOTE: tgt/cur are a handful of per-channel flops, not a RAM, so they take the async reset.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            for (int i = 0; i < CH; i++) begin
                tgt[i] <= NEU_W;
                cur[i] <= NEU_W;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (cmd_hit && cmd.cmd_ch == CHW'(i))      tgt[i] <= cmd_pw_clamped;
                else if (press_ok && sel_ch == CHW'(i))    tgt[i] <= nudge(tgt[i], push_dn);
                if (frame_tick) cur[i] <= slew_step(cur[i], tgt[i]);
            end
        end
    end
endmodule

// File: tb/tb_servo_pwm_array.sv
// Self-checking bench for servo_pwm_array: directed scenarios plus random traffic, every cycle
// compared against an integer reference model of frames, widths and a sliding debounce window.
module tb_servo_pwm_array;
    localparam int CH = 4, W = 20, P = 1000, MIN = 50, MAX = 250, NEU = 150;
    localparam int SLEW = 20, STEP = 10, DEB = 4;

    logic          m_clock = 1'b0;
    logic          p_reset = 1'b0;
    logic          push = 1'b1;
    logic          push_dn = 1'b0;
    logic [1:0]    sel_ch = 2'd0;
    logic [CH-1:0] en = '1;
    logic [CH-1:0] pwm;
    logic          frame_tick;
    logic [W-1:0]  disp_pw;

    servo_pwm_array_if #(.CH(CH), .W(W)) cmd_if ();

    servo_pwm_array #(
        .CH(CH), .W(W), .PERIOD_CYC(P), .MIN_PW(MIN), .MAX_PW(MAX), .NEUTRAL_PW(NEU),
        .SLEW(SLEW), .STEP(STEP), .DEB_CYC(DEB)
    ) dut (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .cmd        (cmd_if),
        .push       (push),
        .push_dn    (push_dn),
        .sel_ch     (sel_ch),
        .en         (en),
        .pwm        (pwm),
        .frame_tick (frame_tick),
        .disp_pw    (disp_pw)
    );

    always #5 m_clock = ~m_clock;

    int            n_assert = 0;
    int            n_fail = 0;
    int            m_cnt;
    int            m_tgt [CH];
    int            m_cur [CH];
    logic [CH-1:0] m_pwm;
    logic          m_clamped, m_live, m_deb;
    bit            hist [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < CH; i++) begin
            m_tgt[i] = NEU;
            m_cur[i] = NEU;
        end
        m_pwm = '0;
        m_clamped = 1'b0;
        m_live = 1'b0;
        m_deb = 1'b1;
        hist.delete();
        repeat (DEB + 2) hist.push_back(1'b1);
    endtask

    // One clock of the specification's rules; hist[k] is push as seen k edges ago.
    task automatic model_step();
        int ch, sel, pw, d;
        bit ft, acc, flip;
        int old_tgt [CH];
        if (!p_reset) begin
            model_reset();
            return;
        end
        ft  = (m_cnt == P - 1);
        acc = cmd_if.cmd_valid && m_live && !ft;
        ch  = int'(cmd_if.cmd_ch);
        sel = int'(sel_ch);
        pw  = int'(cmd_if.cmd_pw);
        old_tgt = m_tgt;
        for (int i = 0; i < CH; i++) m_pwm[i] = en[i] && (m_cnt < m_cur[i]);
        m_clamped = acc && ch < CH && (pw < MIN || pw > MAX);
        hist.push_front(push);
        void'(hist.pop_back());
        flip = 1'b1;
        for (int k = 2; k < DEB + 2; k++) if (hist[k] == m_deb) flip = 1'b0;
        if (acc && ch < CH) m_tgt[ch] = (pw < MIN) ? MIN : (pw > MAX) ? MAX : pw;
        if (flip && m_deb && sel < CH && !(acc && ch == sel)) begin
            if (push_dn) m_tgt[sel] = (old_tgt[sel] - STEP < MIN) ? MIN : old_tgt[sel] - STEP;
            else         m_tgt[sel] = (old_tgt[sel] + STEP > MAX) ? MAX : old_tgt[sel] + STEP;
        end
        if (flip) m_deb = !m_deb;
        if (ft) begin
            for (int i = 0; i < CH; i++) begin
                d = old_tgt[i] - m_cur[i];
                if (d > SLEW)       m_cur[i] = m_cur[i] + SLEW;
                else if (d < -SLEW) m_cur[i] = m_cur[i] - SLEW;
                else                m_cur[i] = old_tgt[i];
            end
        end
        m_cnt = (m_cnt + 1) % P;
        m_live = 1'b1;
    endtask

    task automatic cycle();
        @(posedge m_clock);
        model_step();
        @(negedge m_clock);
        check("pwm", pwm, m_pwm);
        check("frame_tick", frame_tick, m_cnt == P - 1);
        check("cmd_ready", cmd_if.cmd_ready, m_live && m_cnt != P - 1);
        check("cmd_clamped", cmd_if.cmd_clamped, m_clamped);
        check("disp_pw", disp_pw, m_cur[sel_ch]);
    endtask

    task automatic wait_tick();
        int k = 0;
        cycle();
        while (frame_tick !== 1'b1 && k < P + 2) begin
            cycle();
            k++;
        end
        check("tick_timeout", frame_tick, 1'b1);
    endtask

    task automatic send_cmd(input int ch, input int pw, output int waits, output logic clamped);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch = ch[1:0];
        cmd_if.cmd_pw = pw[W-1:0];
        waits = 0;
        while (cmd_if.cmd_ready !== 1'b1 && waits < 4) begin
            cycle();
            waits++;
        end
        cycle();
        cmd_if.cmd_valid = 1'b0;
        clamped = cmd_if.cmd_clamped;
    endtask

    task automatic press(input int low_cycles);
        push = 1'b0;
        repeat (low_cycles) cycle();
        push = 1'b1;
        repeat (8) cycle();
    endtask

    initial begin
        int waits;
        logic cl;
        int high [CH];
        int ticks;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ch = '0;
        cmd_if.cmd_pw = '0;
        model_reset();

        repeat (2) cycle();
        check("rst_pwm", pwm, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_ready", cmd_if.cmd_ready, 0);
        check("rst_disp", disp_pw, NEU);
        p_reset = 1'b1;
        cycle();
        check("ready_after_rst", cmd_if.cmd_ready, 1);

        // Full frame at neutral width on every channel
        wait_tick();
        for (int i = 0; i < CH; i++) high[i] = 0;
        ticks = 0;
        for (int c = 0; c < P; c++) begin
            cycle();
            for (int i = 0; i < CH; i++) high[i] += int'(pwm[i]);
            ticks += int'(frame_tick);
        end
        for (int i = 0; i < CH; i++) check("t1_high_cycles", high[i], NEU);
        check("t1_ticks_per_frame", ticks, 1);

        // Slew toward 200 on channel 1
        sel_ch = 2'd1;
        send_cmd(1, 200, waits, cl);
        check("t2_clamped", cl, 0);
        wait_tick(); cycle(); check("t2_f1", disp_pw, 170);
        wait_tick(); cycle(); check("t2_f2", disp_pw, 190);
        wait_tick(); cycle(); check("t2_f3", disp_pw, 200);
        sel_ch = 2'd0;
        #1 check("t2_other", disp_pw, NEU);

        // Clamping high then low on channel 0
        send_cmd(0, 900, waits, cl);
        check("t3_clamp_hi", cl, 1);
        repeat (5) wait_tick();
        cycle(); check("t3_at_max", disp_pw, MAX);
        send_cmd(0, 10, waits, cl);
        check("t3_clamp_lo", cl, 1);
        repeat (10) wait_tick();
        cycle(); check("t3_at_min", disp_pw, MIN);

        // Command presented on the frame_tick cycle waits exactly one cycle
        wait_tick();
        send_cmd(3, 120, waits, cl);
        check("t4_wait_cycles", waits, 1);

        // Bounce rejected, real press nudges channel 2 up
        sel_ch = 2'd2;
        push_dn = 1'b0;
        press(3);
        press(6);
        wait_tick(); cycle(); check("t5_nudge", disp_pw, 160);
        send_cmd(2, 250, waits, cl);
        press(6);
        repeat (6) wait_tick();
        cycle(); check("t5_saturate", disp_pw, MAX);

        // Command and press on the same channel in the same cycle
        wait_tick(); cycle();
        push = 1'b0;
        repeat (5) cycle();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch = 2'd2;
        cmd_if.cmd_pw = W'(100);
        cycle();
        cmd_if.cmd_valid = 1'b0;
        push = 1'b1;
        repeat (8) wait_tick();
        cycle(); check("t6_cmd_wins", disp_pw, 100);

        // Random traffic against the model
        for (int c = 0; c < 6000; c++) begin
            cmd_if.cmd_valid = ($urandom_range(0, 29) == 0);
            if (cmd_if.cmd_valid) begin
                cmd_if.cmd_ch = 2'($urandom_range(0, 3));
                cmd_if.cmd_pw = W'($urandom_range(0, 320));
            end
            if ($urandom_range(0, 15) == 0) begin
                push = ~push;
                push_dn = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 199) == 0) sel_ch = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) en = CH'($urandom_range(0, 15));
            cycle();
        end
        cmd_if.cmd_valid = 1'b0;
        push = 1'b1;
        en = '1;

        // Asynchronous reset in the middle of a frame
        wait_tick();
        repeat (10) cycle();
        check("pre_rst_pwm", pwm, 4'hF);
        p_reset = 1'b0;
        model_reset();
        #1;
        check("mid_rst_pwm", pwm, 0);
        check("mid_rst_disp", disp_pw, NEU);
        check("mid_rst_ready", cmd_if.cmd_ready, 0);
        cycle();
        p_reset = 1'b1;
        repeat (3) cycle();
        check("post_rst_ready", cmd_if.cmd_ready, 1);
        check("post_rst_disp", disp_pw, NEU);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
